// File: rtl/spi_arb_pkg.sv
// Shared types and helpers for the SPI bus arbiter.
package spi_arb_pkg;

    typedef enum logic [1:0] {IDLE, SEND, BUSY, HOLD} state_t;

    localparam int unsigned CMD_W   = 16;
    localparam int unsigned RESP_W  = 16;
    localparam int unsigned MAX_REQ = 8;

    function automatic int unsigned onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first eligible requester at or above rr_ptr, wrapping.
module rr_picker
    import spi_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 2,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    int unsigned pos;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        pos    = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            pos = 32'(rr_ptr) + i;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            if (!valid && eligible[pos]) begin
                winner[pos] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

    assign idx = IDX_W'(onehot_to_idx(MAX_REQ'(winner)));

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI master among NUM_REQ requesters, one frame per grant.
// Optional SPI_ARB_TIMEOUT_EN adds a BUSY/HOLD watchdog that releases a stuck grant via err_out.
module spi_bus_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned TO_CYCLES = 4096
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       lock,
    input  logic [CMD_W*NUM_REQ-1:0] cmd_flat,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done_out,
    output logic [RESP_W-1:0]        resp_out,
    output logic [NUM_REQ-1:0]       err_out,
    output logic                     snd,
    output logic [CMD_W-1:0]         cmd,
    input  logic                     spi_done,
    input  logic [RESP_W-1:0]        spi_resp
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    state_t               state, state_nx;
    logic [IDX_W-1:0]     owner, owner_nx, rr_ptr, rr_ptr_nx, pick_idx, next_ptr;
    logic [NUM_REQ-1:0]   gnt_nx, done_nx, pick_oh;
    logic                 pick_valid;
    logic [CMD_W-1:0]     cmd_nx, pick_cmd, own_cmd;
    logic [RESP_W-1:0]    resp_nx;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .eligible (req & ~done_out),
        .rr_ptr   (rr_ptr),
        .winner   (pick_oh),
        .idx      (pick_idx),
        .valid    (pick_valid)
    );

    always_comb begin
        pick_cmd = '0;
        own_cmd  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) pick_cmd = cmd_flat[i*CMD_W +: CMD_W];
            if (owner == IDX_W'(i))    own_cmd  = cmd_flat[i*CMD_W +: CMD_W];
        end
    end

    assign next_ptr = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    assign snd      = (state == SEND);

`ifdef SPI_ARB_TIMEOUT_EN
    logic [15:0]        to_cnt, to_cnt_nx;
    logic [NUM_REQ-1:0] err_nx;
    logic               to_hit;
    assign to_hit = (to_cnt == 16'(TO_CYCLES - 1));
`else
    assign err_out = '0;
`endif

    always_comb begin
        state_nx  = state;
        gnt_nx    = gnt;
        owner_nx  = owner;
        rr_ptr_nx = rr_ptr;
        cmd_nx    = cmd;
        resp_nx   = resp_out;
        done_nx   = '0;
`ifdef SPI_ARB_TIMEOUT_EN
        err_nx    = '0;
`endif
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    gnt_nx   = pick_oh;
                    owner_nx = pick_idx;
                    cmd_nx   = pick_cmd;
                    state_nx = SEND;
                end
            end
            SEND: state_nx = BUSY;
            BUSY: begin
                if (spi_done) begin
                    resp_nx        = spi_resp;
                    done_nx[owner] = 1'b1;
                    if (lock[owner]) begin
                        state_nx = HOLD;
                    end else begin
                        gnt_nx    = '0;
                        rr_ptr_nx = next_ptr;
                        state_nx  = IDLE;
                    end
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (to_hit) begin
                    err_nx[owner] = 1'b1;
                    gnt_nx        = '0;
                    rr_ptr_nx     = next_ptr;
                    state_nx      = IDLE;
                end
`endif
            end
            HOLD: begin
                // done_out masks the owner's stale req for the cycle right after its frame
                if (req[owner] && !done_out[owner]) begin
                    cmd_nx   = own_cmd;
                    state_nx = SEND;
                end else if (!lock[owner]) begin
                    gnt_nx    = '0;
                    rr_ptr_nx = next_ptr;
                    state_nx  = IDLE;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (to_hit) begin
                    err_nx[owner] = 1'b1;
                    gnt_nx        = '0;
                    rr_ptr_nx     = next_ptr;
                    state_nx      = IDLE;
                end
`endif
            end
            default: state_nx = IDLE;
        endcase
`ifdef SPI_ARB_TIMEOUT_EN
        if ((state_nx == BUSY || state_nx == HOLD) && state_nx != state)
            to_cnt_nx = '0;
        else if (state == BUSY || state == HOLD)
            to_cnt_nx = to_cnt + 16'd1;
        else
            to_cnt_nx = to_cnt;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            owner    <= '0;
            rr_ptr   <= '0;
            cmd      <= '0;
            resp_out <= '0;
            done_out <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            err_out  <= '0;
            to_cnt   <= '0;
`endif
        end else begin
            state    <= state_nx;
            gnt      <= gnt_nx;
            owner    <= owner_nx;
            rr_ptr   <= rr_ptr_nx;
            cmd      <= cmd_nx;
            resp_out <= resp_nx;
            done_out <= done_nx;
`ifdef SPI_ARB_TIMEOUT_EN
            err_out  <= err_nx;
            to_cnt   <= to_cnt_nx;
`endif
        end
    end

endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
- Shares one SPI_mnrch master (snd/cmd/done/resp) among NUM_REQ requesters, e.g. the A2D poller and an inertial-sensor front end.
- Uses round-robin arbitration; one 16-bit SPI frame per grant.
- A lock input keeps the grant across back-to-back frames, so the A2D command-then-read pair is never interleaved.
- Sits between the requester blocks and the single SPI_mnrch instance.

Parameters:
- NUM_REQ, 2: number of requesters (2..8).
- TO_CYCLES, 4096: timeout limit in clk cycles; used only with SPI_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  NUM_REQ  per-requester frame request, level.
- lock  in  NUM_REQ  requester keeps the grant after the current frame.
- cmd_flat  in  16*NUM_REQ  per-requester command; requester i uses bits [16i+15:16i].
- gnt  out  NUM_REQ  one-hot grant, registered.
- done_out  out  NUM_REQ  one-cycle frame-complete pulse to the owner.
- resp_out  out  16  response of the last completed frame, registered.
- err_out  out  NUM_REQ  timeout pulse (feature only, else 0).
- snd  out  1  start pulse to SPI master.
- cmd  out  16  command to SPI master.
- spi_done  in  1  SPI master done.
- spi_resp  in  16  SPI master response.

Behaviour:
- Reset values: gnt=0, done_out=0, err_out=0, resp_out=0, snd=0, cmd=0, state=IDLE, rr_ptr=0.
- FSM states: IDLE, SEND, BUSY, HOLD.
- IDLE:
  - Eligible requesters are req & ~done_out. Requesters with done_out high this cycle are masked, so a requester whose req drops one cycle after done_out does not get a second frame.
  - If any requester is eligible, pick the first set bit scanning upward from rr_ptr, with wrap-around.
  - Register gnt, owner index, and cmd <= winner's cmd slice; go to SEND.
- SEND: snd=1 for exactly one cycle; go to BUSY.
  - Latency: req sampled at edge E gives snd high in cycle E+1.
- cmd stability: cmd holds stable from SEND until the next load, never mid-frame.
- BUSY: wait for spi_done.
  - On spi_done: resp_out <= spi_resp; done_out[owner] <= 1 for one cycle.
  - If lock[owner]=1 at that cycle, go to HOLD with gnt retained.
  - Otherwise clear gnt, set rr_ptr <= owner+1 (mod NUM_REQ), go to IDLE.
- HOLD (grant retained; requests from other requesters are ignored):
  - If req[owner] & ~done_out[owner]: cmd <= owner's slice; go to SEND.
  - Else if lock[owner]=0: release as above and go to IDLE.
  - Else stay.
- spi_done outside BUSY is ignored.
- A requester dropping req mid-frame is ignored; the frame completes and done_out still pulses.
- Simultaneous requests: round-robin guarantees every continuously requesting unlocked requester is granted within NUM_REQ frames.
- Async reset mid-frame returns to reset values immediately. The SPI master is reset by the same rst_n.

Optional Feature:
- Macro: SPI_ARB_TIMEOUT_EN.
- With the macro:
  - A 16-bit counter clears on entry to BUSY or HOLD and increments while in either state.
  - At TO_CYCLES-1: err_out[owner] pulses one cycle, done_out is not pulsed, the grant is released, rr_ptr advances, and the FSM goes to IDLE.
- Without the macro: no counter; err_out is tied to 0; HOLD lasts indefinitely.

Decomposition:
- Package spi_arb_pkg:
  - state_t enum {IDLE, SEND, BUSY, HOLD}, 2 bits.
  - CMD_W=16, RESP_W=16.
  - Function onehot_to_idx.
- Sub-module rr_picker: combinational. Inputs eligible mask and rr_ptr; outputs one-hot winner and index with wrap-around search. Parameterised by NUM_REQ.

Test Plan:
- req=01, cmd0=16'h0800, spi_done 30 cycles after snd with spi_resp=16'h0ABC -> snd one cycle after req; cmd=16'h0800; done_out=01 one cycle; resp_out=16'h0ABC; gnt=00 afterwards.
- req=11 held continuously, no lock -> grants alternate 01,10,01,10; cmd tracks the owner each frame.
- Requester 0 with lock=1 issues two frames (16'h1800 then 16'h0000) while req1=1 -> both req0 frames complete before gnt=10.
- Single requester drops req one cycle after done_out -> exactly one snd pulse.
- spi_done pulsed in IDLE -> no done_out, resp_out unchanged.
- rst_n low during BUSY -> all outputs 0 immediately; after release a new req starts a clean frame.
- With SPI_ARB_TIMEOUT_EN, TO_CYCLES=64, spi_done withheld -> err_out[owner] pulses at cycle 64 of BUSY; no done_out; next requester granted.
